// File: rtl/run_extrema_pkg.sv
// Shared types for the run_extrema block: FSM encoding and
// one-hot {eq,gt,lt} comparison codes.
package run_extrema_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      TRACK = 2'd1,
      SAT   = 2'd2
   } state_t;

   localparam logic [2:0] CMP_NONE = 3'b000;
   localparam logic [2:0] CMP_EQ   = 3'b100;
   localparam logic [2:0] CMP_GT   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b001;

endpackage

// File: rtl/run_extrema_mag_cmp.sv
// Unsigned magnitude comparator: res is one-hot {eq,gt,lt}
// describing a relative to b.
module mag_cmp
   import run_extrema_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [2:0]       res
);

   always_comb begin
      res = CMP_NONE;
      unique case (1'b1)
         (a == b): res = CMP_EQ;
         (a >  b): res = CMP_GT;
         (a <  b): res = CMP_LT;
      endcase
   end

endmodule

// File: rtl/run_extrema.sv
// Running max/min tracker with saturating sample count.
// Optional tie counter enabled by RUN_EXTREMA_TIE_CNT_EN.
module run_extrema
   import run_extrema_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] min_val,
   output logic [CNT_W-1:0] cnt,
   output logic [2:0]       cmp_code,
   output logic             upd,
   output logic             sat
`ifdef RUN_EXTREMA_TIE_CNT_EN
   ,
   output logic [CNT_W-1:0] tie_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] max_q, max_nxt;
   logic [WIDTH-1:0] min_q, min_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [2:0]       cmp_q, cmp_nxt;
   logic             upd_q, upd_nxt;
   logic [2:0]       max_res;
   logic [2:0]       min_res;
   logic             accept;
`ifdef RUN_EXTREMA_TIE_CNT_EN
   logic [CNT_W-1:0] tie_q, tie_nxt;
`endif

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
      .a   (in_data),
      .b   (max_q),
      .res (max_res)
   );

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
      .a   (in_data),
      .b   (min_q),
      .res (min_res)
   );

   assign in_ready = (state_q != SAT) && !clear;
   assign accept   = in_valid && in_ready;

   assign max_val  = max_q;
   assign min_val  = min_q;
   assign cnt      = cnt_q;
   assign cmp_code = cmp_q;
   assign upd      = upd_q;
   assign sat      = (state_q == SAT);
`ifdef RUN_EXTREMA_TIE_CNT_EN
   assign tie_cnt  = tie_q;
`endif

   always_comb begin
      state_nxt = state_q;
      max_nxt   = max_q;
      min_nxt   = min_q;
      cnt_nxt   = cnt_q;
      cmp_nxt   = cmp_q;
      upd_nxt   = 1'b0;
`ifdef RUN_EXTREMA_TIE_CNT_EN
      tie_nxt   = tie_q;
`endif
      if (clear) begin
         state_nxt = EMPTY;
         max_nxt   = '0;
         min_nxt   = '0;
         cnt_nxt   = '0;
         cmp_nxt   = CMP_NONE;
`ifdef RUN_EXTREMA_TIE_CNT_EN
         tie_nxt   = '0;
`endif
      end else if (accept) begin
         unique case (state_q)
            EMPTY: begin
               max_nxt = in_data;
               min_nxt = in_data;
               cnt_nxt = CNT_ONE;
               cmp_nxt = CMP_EQ;
`ifdef RUN_EXTREMA_TIE_CNT_EN
               tie_nxt = CNT_ONE;
`endif
            end
            TRACK: begin
               cmp_nxt = max_res;
               cnt_nxt = cnt_q + CNT_ONE;
               if (max_res == CMP_GT) begin
                  max_nxt = in_data;
               end
               if (min_res == CMP_LT) begin
                  min_nxt = in_data;
               end
`ifdef RUN_EXTREMA_TIE_CNT_EN
               if (max_res == CMP_GT) begin
                  tie_nxt = CNT_ONE;
               end else if (max_res == CMP_EQ &&
                            tie_q != CNT_MAX) begin
                  tie_nxt = tie_q + CNT_ONE;
               end
`endif
            end
            default: ;
         endcase
         upd_nxt = 1'b1;
         // Full count locks the run until clear or reset
         state_nxt = (cnt_nxt == CNT_MAX) ? SAT : TRACK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         max_q   <= '0;
         min_q   <= '0;
         cnt_q   <= '0;
         cmp_q   <= CMP_NONE;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         max_q   <= max_nxt;
         min_q   <= min_nxt;
         cnt_q   <= cnt_nxt;
         cmp_q   <= cmp_nxt;
         upd_q   <= upd_nxt;
      end
   end

`ifdef RUN_EXTREMA_TIE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tie_q <= '0;
      end else begin
         tie_q <= tie_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_run_extrema.sv
// Self-checking bench for run_extrema (WIDTH=4, CNT_W=3):
// directed vectors, corner sequences, random vs. history model.
module tb_run_extrema;

   localparam int W = 4;
   localparam int CW = 3;
   localparam int FULL = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready;
   logic [W-1:0]  max_val;
   logic [W-1:0]  min_val;
   logic [CW-1:0] cnt;
   logic [2:0]    cmp_code;
   logic          upd;
   logic          sat;
`ifdef RUN_EXTREMA_TIE_CNT_EN
   logic [CW-1:0] tie_cnt;
`endif

   int checks = 0;
   int errors = 0;

   run_extrema #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .max_val  (max_val),
      .min_val  (min_val),
      .cnt      (cnt),
      .cmp_code (cmp_code),
      .upd      (upd),
      .sat      (sat)
`ifdef RUN_EXTREMA_TIE_CNT_EN
      ,
      .tie_cnt  (tie_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       vld;
      logic [3:0] d;
      logic [3:0] emax;
      logic [3:0] emin;
      logic [2:0] ecnt;
      logic [2:0] ecmp;
      logic       eupd;
   } vec_t;

   vec_t tbl[7];
   int   hist[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic apply(input logic c, input logic v,
                        input logic [W-1:0] d);
      clear = c;
      in_valid = v;
      in_data = d;
      @(posedge clk);
      #1;
   endtask

   function automatic int hmax();
      int m = 0;
      foreach (hist[i]) if (hist[i] > m) m = hist[i];
      return m;
   endfunction

   function automatic int hmin();
      int m = 15;
      if (hist.size() == 0) return 0;
      foreach (hist[i]) if (hist[i] < m) m = hist[i];
      return m;
   endfunction

   function automatic int htie();
      int n = 0;
      int m = hmax();
      if (hist.size() == 0) return 0;
      foreach (hist[i]) if (hist[i] == m) n++;
      return n;
   endfunction

   initial begin
      int nup;
      logic [W-1:0] mx;
      logic [2:0] ecmp;
      logic eupd;

      tbl[0] = '{1'b0, 1'b1, 4'd5,  4'd5, 4'd5, 3'd1, 3'b100, 1'b1};
      tbl[1] = '{1'b0, 1'b1, 4'd9,  4'd9, 4'd5, 3'd2, 3'b010, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 4'd3,  4'd9, 4'd3, 3'd3, 3'b001, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 4'd9,  4'd9, 4'd3, 3'd4, 3'b100, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 4'd1,  4'd9, 4'd3, 3'd4, 3'b100, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 4'd15, 4'd0, 4'd0, 3'd0, 3'b000, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 4'd2,  4'd2, 4'd2, 3'd1, 3'b100, 1'b1};

      #12;
      chk("rst_max", max_val, 0);
      chk("rst_min", min_val, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_cmp", cmp_code, 0);
      chk("rst_upd", upd, 0);
      chk("rst_sat", sat, 0);
      chk("rst_rdy", in_ready, 1);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         apply(tbl[i].clr, tbl[i].vld, tbl[i].d);
         chk($sformatf("vec%0d_max", i), max_val, tbl[i].emax);
         chk($sformatf("vec%0d_min", i), min_val, tbl[i].emin);
         chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].ecnt);
         chk($sformatf("vec%0d_cmp", i), cmp_code, tbl[i].ecmp);
         chk($sformatf("vec%0d_upd", i), upd, tbl[i].eupd);
      end

      apply(1'b1, 1'b0, '0);
      for (int i = 0; i < FULL; i++) begin
         apply(1'b0, 1'b1, W'($urandom_range(0, 15)));
         chk("sat_early", sat, (i == FULL - 1) ? 1 : 0);
      end
      chk("sat_cnt", cnt, FULL);
      chk("sat_rdy", in_ready, 0);
      mx = max_val;
      apply(1'b0, 1'b1, 4'd15);
      chk("sat_hold_cnt", cnt, FULL);
      chk("sat_hold_upd", upd, 0);
      chk("sat_hold_max", max_val, mx);
      apply(1'b1, 1'b0, '0);
      chk("sat_exit", sat, 0);
      chk("sat_exit_cnt", cnt, 0);

      apply(1'b0, 1'b1, 4'd7);
      apply(1'b0, 1'b1, 4'd2);
      in_valid = 1'b1;
      in_data = 4'd9;
      #3 rst_n = 1'b0;
      #1;
      chk("arst_max", max_val, 0);
      chk("arst_min", min_val, 0);
      chk("arst_cnt", cnt, 0);
      chk("arst_cmp", cmp_code, 0);
      chk("arst_rdy", in_ready, 1);
      @(posedge clk);
      #1;
      chk("arst_drop", cnt, 0);
      #2 rst_n = 1'b1;
      in_data = 4'd11;
      @(posedge clk);
      #1;
      chk("post_rst_cmp", cmp_code, 3'b100);
      chk("post_rst_cnt", cnt, 1);
      chk("post_rst_max", max_val, 11);

      apply(1'b1, 1'b0, '0);
      nup = 0;
      apply(1'b0, 1'b1, 4'd4);
      nup += int'(upd);
      apply(1'b0, 1'b0, W'($urandom_range(0, 15)));
      nup += int'(upd);
      apply(1'b0, 1'b1, 4'd12);
      nup += int'(upd);
      apply(1'b0, 1'b0, '0);
      nup += int'(upd);
      apply(1'b0, 1'b0, '0);
      nup += int'(upd);
      chk("tog_pulses", nup, 2);
      chk("tog_max", max_val, 12);
      chk("tog_min", min_val, 4);

`ifdef RUN_EXTREMA_TIE_CNT_EN
      begin
         int tv[5] = '{6, 6, 6, 8, 8};
         int te[5] = '{1, 2, 3, 1, 2};
         apply(1'b1, 1'b0, '0);
         chk("tie_clr", tie_cnt, 0);
         for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, W'(tv[i]));
            chk($sformatf("tie%0d", i), tie_cnt, te[i]);
         end
      end
`endif

      apply(1'b1, 1'b0, '0);
      hist.delete();
      ecmp = 3'b000;
      eupd = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic c, v;
         logic [W-1:0] d;
         int pm;
         c = ($urandom_range(0, 15) == 0);
         v = ($urandom_range(0, 2) != 0);
         d = W'($urandom_range(0, 15));
         eupd = 1'b0;
         if (c) begin
            hist.delete();
            ecmp = 3'b000;
         end else if (v && hist.size() < FULL) begin
            if (hist.size() == 0) begin
               ecmp = 3'b100;
            end else begin
               pm = hmax();
               ecmp = (int'(d) == pm) ? 3'b100 :
                      (int'(d) > pm) ? 3'b010 : 3'b001;
            end
            hist.push_back(int'(d));
            eupd = 1'b1;
         end
         apply(c, v, d);
         chk("rnd_max", max_val, hmax());
         chk("rnd_min", min_val, hmin());
         chk("rnd_cnt", cnt, hist.size());
         chk("rnd_cmp", cmp_code, ecmp);
         chk("rnd_upd", upd, eupd);
         chk("rnd_sat", sat, (hist.size() == FULL) ? 1 : 0);
         chk("rnd_rdy", in_ready,
             (hist.size() != FULL && !c) ? 1 : 0);
`ifdef RUN_EXTREMA_TIE_CNT_EN
         chk("rnd_tie", tie_cnt, htie());
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
